// File: rtl/alu_pipe.sv
// Pipelined integer ALU functional unit with valid/ready handshakes on both
// sides, full backpressure and a global flush. The result is computed in the
// accept cycle and then carried through STAGES registers with its tags.
module alu_pipe #(
  parameter int XLEN      = 32,
  parameter int P_WIDTH   = 6,
  parameter int ROB_WIDTH = 5,
  parameter int STAGES    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_aluop,
  input  logic                 in_m1_sel,
  input  logic                 in_m2_sel,
  input  logic                 in_rs1_use,
  input  logic                 in_rs2_use,
  input  logic [P_WIDTH-1:0]   in_rs1_paddr,
  input  logic [P_WIDTH-1:0]   in_rs2_paddr,
  input  logic [31:0]          in_pc,
  input  logic [XLEN-1:0]      in_imm,
  input  logic [P_WIDTH-1:0]   in_pd,
  input  logic                 in_rd_we,
  input  logic [ROB_WIDTH-1:0] in_rob_idx,
  output logic [P_WIDTH-1:0]   rs1_paddr,
  output logic [P_WIDTH-1:0]   rs2_paddr,
  input  logic [XLEN-1:0]      p1_data,
  input  logic [XLEN-1:0]      p2_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_data,
  output logic [P_WIDTH-1:0]   out_pd,
  output logic                 out_rd_we,
  output logic [ROB_WIDTH-1:0] out_rob_idx,
  output logic                 out_illegal
);

  localparam int SH_W = (XLEN == 64) ? 6 : 5;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLT  = 4'd2,
    OP_SLTU = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_OR   = 4'd6,
    OP_AND  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9
  } aluop_e;

  typedef struct packed {
    logic [XLEN-1:0]      data;
    logic [P_WIDTH-1:0]   pd;
    logic                 rd_we;
    logic [ROB_WIDTH-1:0] rob_idx;
    logic                 illegal;
  } entry_t;

  logic [XLEN-1:0] op_a, op_b, alu_res;
  logic [SH_W-1:0] shamt;
  logic            alu_illegal;

  entry_t            stg  [STAGES];
  entry_t            e_in [STAGES];
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] adv;

  assign rs1_paddr = in_rs1_use ? in_rs1_paddr : '0;
  assign rs2_paddr = in_rs2_use ? in_rs2_paddr : '0;

  // Operand selection and the ALU proper, evaluated in the accept cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through the case can leave it unassigned and infer a latch.
    alu_res     = '0;
    alu_illegal = 1'b0;
    op_a        = in_m1_sel ? XLEN'(in_pc) : p1_data;
    op_b        = in_m2_sel ? in_imm : p2_data;
    shamt       = op_b[SH_W-1:0];
    case (aluop_e'(in_aluop))
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
      OP_SLTU: alu_res = XLEN'(op_a < op_b);
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_OR:   alu_res = op_a | op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = XLEN'($signed(op_a) >>> shamt);
      default: alu_illegal = 1'b1;
    endcase
  end

  // Advance chain: a stage moves if it or any stage downstream is empty, or
  // the output handshakes. Walked from the output back toward the input.
  always_comb begin
    logic go;
    adv = '0;
    go  = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      go     = go | ~vld[k];
      adv[k] = go;
    end
  end

  // What each stage would load if it advances: stage 0 takes the new op,
  // later stages take their predecessor.
  always_comb begin
    v_in[0]         = in_valid & ~flush;
    e_in[0].data    = alu_res;
    e_in[0].pd      = in_pd;
    e_in[0].rd_we   = in_rd_we;
    e_in[0].rob_idx = in_rob_idx;
    e_in[0].illegal = alu_illegal;
    for (int k = 1; k < STAGES; k++) begin
      v_in[k] = vld[k-1];
      e_in[k] = stg[k-1];
    end
  end

  assign in_ready = adv[0];

  // Valid bits: cleared by reset or flush, otherwise refilled on advance.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      vld <= '0;
    end else if (flush) begin
      vld <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) vld[k] <= v_in[k];
      end
    end
  end

  // Payload registers: only written when a valid entry moves in, so an empty
  // stage keeps its last contents and the output stage keeps its reset zeros.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == STAGES - 1) begin : g_out
      // Output stage payload, cleared by reset so out_* read zero.
      always_ff @(posedge clk) begin
        if (!rst) stg[k] <= '0;
        else if (adv[k] && v_in[k]) stg[k] <= e_in[k];
      end
    end else begin : g_mid
      // Inner stage payload; qualified by its valid bit.
      always_ff @(posedge clk) begin
        // NOTE: inner payload needs no reset; the valid bit alone decides
        // whether its contents mean anything.
        if (adv[k] && v_in[k]) stg[k] <= e_in[k];
      end
    end
  end

  assign out_valid   = vld[STAGES-1];
  assign out_data    = stg[STAGES-1].data;
  assign out_pd      = stg[STAGES-1].pd;
  assign out_rd_we   = stg[STAGES-1].rd_we;
  assign out_rob_idx = stg[STAGES-1].rob_idx;
  assign out_illegal = stg[STAGES-1].illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe: two 32-bit instances (STAGES=2 and STAGES=1) share
// one random stimulus stream and are scored against a queue-based model; a
// 64-bit STAGES=4 instance gets directed shift/reserved-op checks.
module tb_alu_pipe;

  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic        m1, m2, u1, u2;
    logic [5:0]  r1, r2, pd;
    logic        we;
    logic [4:0]  rob;
    logic [31:0] pc, imm;
  } op_t;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  pd;
    logic        we;
    logic [4:0]  rob;
    logic        ill;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [3:0]  in_aluop;
  logic        in_m1_sel, in_m2_sel, in_rs1_use, in_rs2_use, in_rd_we;
  logic [5:0]  in_rs1_paddr, in_rs2_paddr, in_pd;
  logic [4:0]  in_rob_idx;
  logic [31:0] in_pc, in_imm;

  logic [1:0][5:0]  rs1_pa, rs2_pa, opd;
  logic [1:0][31:0] p1, p2, od;
  logic [1:0][4:0]  orob;
  logic [1:0]       ir, ov, owe, oill;

  logic [31:0] prf [64];

  logic        w_in_valid, w_ir, w_ov, w_owe, w_oill;
  logic [3:0]  w_op;
  logic [63:0] w_p1, w_p2, w_od;
  logic [5:0]  w_rs1pa, w_rs2pa, w_opd;
  logic [4:0]  w_orob;

  exp_t q[2][$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic obs_acc0;

  always #5 clk = ~clk;

  assign p1[0] = prf[rs1_pa[0]];
  assign p2[0] = prf[rs2_pa[0]];
  assign p1[1] = prf[rs1_pa[1]];
  assign p2[1] = prf[rs2_pa[1]];

  alu_pipe #(.XLEN(32), .STAGES(2)) u_s2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_aluop(in_aluop), .in_m1_sel(in_m1_sel), .in_m2_sel(in_m2_sel),
    .in_rs1_use(in_rs1_use), .in_rs2_use(in_rs2_use),
    .in_rs1_paddr(in_rs1_paddr), .in_rs2_paddr(in_rs2_paddr), .in_pc(in_pc),
    .in_imm(in_imm), .in_pd(in_pd), .in_rd_we(in_rd_we), .in_rob_idx(in_rob_idx),
    .rs1_paddr(rs1_pa[0]), .rs2_paddr(rs2_pa[0]), .p1_data(p1[0]), .p2_data(p2[0]),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_pd(opd[0]),
    .out_rd_we(owe[0]), .out_rob_idx(orob[0]), .out_illegal(oill[0])
  );

  alu_pipe #(.XLEN(32), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_aluop(in_aluop), .in_m1_sel(in_m1_sel), .in_m2_sel(in_m2_sel),
    .in_rs1_use(in_rs1_use), .in_rs2_use(in_rs2_use),
    .in_rs1_paddr(in_rs1_paddr), .in_rs2_paddr(in_rs2_paddr), .in_pc(in_pc),
    .in_imm(in_imm), .in_pd(in_pd), .in_rd_we(in_rd_we), .in_rob_idx(in_rob_idx),
    .rs1_paddr(rs1_pa[1]), .rs2_paddr(rs2_pa[1]), .p1_data(p1[1]), .p2_data(p2[1]),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_pd(opd[1]),
    .out_rd_we(owe[1]), .out_rob_idx(orob[1]), .out_illegal(oill[1])
  );

  alu_pipe #(.XLEN(64), .STAGES(4)) u_w64 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(w_in_valid), .in_ready(w_ir),
    .in_aluop(w_op), .in_m1_sel(1'b0), .in_m2_sel(1'b0),
    .in_rs1_use(1'b1), .in_rs2_use(1'b1),
    .in_rs1_paddr(6'd3), .in_rs2_paddr(6'd4), .in_pc(32'h0),
    .in_imm(64'h0), .in_pd(6'd9), .in_rd_we(1'b1), .in_rob_idx(5'd4),
    .rs1_paddr(w_rs1pa), .rs2_paddr(w_rs2pa), .p1_data(w_p1), .p2_data(w_p2),
    .out_valid(w_ov), .out_ready(1'b1), .out_data(w_od), .out_pd(w_opd),
    .out_rd_we(w_owe), .out_rob_idx(w_orob), .out_illegal(w_oill)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic int stg_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  // Reference ALU written from the operation definitions with wide integers.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int     sh = int'(b[4:0]);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'h0, a});
    longint ub = longint'({32'h0, b});
    case (op)
      4'd0:    return 32'(ua + ub);
      4'd1:    return 32'(ua - ub);
      4'd2:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd3:    return (ua < ub) ? 32'd1 : 32'd0;
      4'd4:    return a ^ b;
      4'd5:    return 32'(ua * (longint'(1) << sh));
      4'd6:    return a | b;
      4'd7:    return a & b;
      4'd8:    return 32'(ua / (longint'(1) << sh));
      4'd9:    return 32'(sa >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  function automatic op_t nop();
    op_t o;
    o = '{default: '0};
    return o;
  endfunction

  function automatic op_t mk(input logic [3:0] op, input logic [5:0] r1, input logic [31:0] imm,
                             input logic [5:0] pd, input logic [4:0] rob);
    op_t o;
    o = nop();
    o.v = 1'b1; o.op = op; o.u1 = 1'b1; o.r1 = r1; o.m2 = 1'b1; o.imm = imm;
    o.pd = pd; o.we = 1'b1; o.rob = rob;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.v   = ($urandom_range(0, 3) != 0);
    o.op  = ($urandom_range(0, 9) == 0) ? 4'(10 + $urandom_range(0, 5)) : 4'($urandom_range(0, 9));
    o.m1  = ($urandom_range(0, 4) == 0);
    o.m2  = $urandom_range(0, 1) == 1;
    o.u1  = $urandom_range(0, 3) != 0;
    o.u2  = $urandom_range(0, 3) != 0;
    o.r1  = 6'($urandom);
    o.r2  = 6'($urandom);
    o.pd  = 6'($urandom);
    o.we  = $urandom_range(0, 1) == 1;
    o.rob = 5'($urandom);
    o.pc  = $urandom;
    o.imm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
    return o;
  endfunction

  // One clock of the shared 32-bit stimulus: drive, score both instances,
  // update the model for the coming edge, then move to the next negedge.
  task automatic step(input op_t o, input logic ordy, input logic fl);
    logic [31:0] a, b;
    exp_t        e;
    logic        exp_ir, exp_ov;
    in_valid = o.v; in_aluop = o.op; in_m1_sel = o.m1; in_m2_sel = o.m2;
    in_rs1_use = o.u1; in_rs2_use = o.u2; in_rs1_paddr = o.r1; in_rs2_paddr = o.r2;
    in_pd = o.pd; in_rd_we = o.we; in_rob_idx = o.rob; in_pc = o.pc; in_imm = o.imm;
    out_ready = ordy; flush = fl;
    #1;
    a = o.m1 ? o.pc : prf[o.u1 ? o.r1 : 6'd0];
    b = o.m2 ? o.imm : prf[o.u2 ? o.r2 : 6'd0];
    e.ill  = (o.op >= 4'd10);
    e.data = e.ill ? 32'd0 : ref_alu(o.op, a, b);
    e.pd = o.pd; e.we = o.we; e.rob = o.rob; e.acc = cyc;
    check("rs1_paddr", rs1_pa[0], o.u1 ? o.r1 : 6'd0);
    check("rs2_paddr", rs2_pa[0], o.u2 ? o.r2 : 6'd0);
    obs_acc0 = ir[0] && o.v && !fl;
    for (int d = 0; d < 2; d++) begin
      exp_ir = ordy || (q[d].size() < stg_of(d));
      exp_ov = (q[d].size() > 0) && (cyc >= q[d][0].acc + stg_of(d));
      check($sformatf("in_ready[%0d]", d), ir[d], exp_ir);
      check($sformatf("out_valid[%0d]", d), ov[d], exp_ov);
      if (exp_ov) begin
        check($sformatf("out_data[%0d]", d), od[d], q[d][0].data);
        check($sformatf("out_pd[%0d]", d), opd[d], q[d][0].pd);
        check($sformatf("out_rd_we[%0d]", d), owe[d], q[d][0].we);
        check($sformatf("out_rob_idx[%0d]", d), orob[d], q[d][0].rob);
        check($sformatf("out_illegal[%0d]", d), oill[d], q[d][0].ill);
        if (ordy) void'(q[d].pop_front());
      end
      if (fl) q[d].delete();
      else if (o.v && exp_ir) q[d].push_back(e);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; w_in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    rst = 1'b1;
    q[0].delete();
    q[1].delete();
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst out_valid[%0d]", d), ov[d], 1'b0);
      check($sformatf("rst out_data[%0d]", d), od[d], 32'd0);
      check($sformatf("rst out_pd[%0d]", d), opd[d], 6'd0);
      check($sformatf("rst out_rd_we[%0d]", d), owe[d], 1'b0);
      check($sformatf("rst out_rob_idx[%0d]", d), orob[d], 5'd0);
      check($sformatf("rst out_illegal[%0d]", d), oill[d], 1'b0);
      check($sformatf("rst in_ready[%0d]", d), ir[d], 1'b1);
    end
    check("rst w64 out_valid", w_ov, 1'b0);
    check("rst w64 out_data", w_od, 64'd0);
    check("rst w64 in_ready", w_ir, 1'b1);
  endtask

  // Directed op on the 64-bit, 4-stage instance; measures latency with a bound.
  task automatic run_w(input string tag, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp_d, input logic exp_ill);
    int   lat;
    logic found;
    w_in_valid = 1'b1; w_op = op; w_p1 = a; w_p2 = b;
    #1;
    check({tag, " in_ready"}, w_ir, 1'b1);
    check({tag, " rs1_paddr"}, w_rs1pa, 6'd3);
    @(posedge clk);
    @(negedge clk);
    w_in_valid = 1'b0;
    found = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      if (!found) begin
        if (w_ov) begin
          found = 1'b1;
          lat = i;
        end else begin
          @(negedge clk);
        end
      end
    end
    check({tag, " latency"}, lat, 4);
    check({tag, " out_data"}, w_od, exp_d);
    check({tag, " out_illegal"}, w_oill, exp_ill);
    check({tag, " out_pd"}, w_opd, 6'd9);
    @(negedge clk);
  endtask

  initial begin
    op_t bp [4];
    int  idx, nacc;
    for (int i = 0; i < 64; i++) prf[i] = $urandom;
    prf[0] = 32'd0;
    prf[5] = 32'h0000_0010;
    prf[1] = 32'hFFFF_FFFF;
    prf[2] = 32'h8000_0000;
    w_op = 4'd0; w_p1 = 64'd0; w_p2 = 64'd0;
    in_aluop = 4'd0; in_m1_sel = 1'b0; in_m2_sel = 1'b0; in_rs1_use = 1'b0;
    in_rs2_use = 1'b0; in_rs1_paddr = 6'd0; in_rs2_paddr = 6'd0; in_pd = 6'd0;
    in_rd_we = 1'b0; in_rob_idx = 5'd0; in_pc = 32'd0; in_imm = 32'd0;
    @(negedge clk);
    do_reset();

    // add with immediate: 0x10 + 0xFFFF_FFF0 wraps to 0
    step(mk(4'd0, 6'd5, 32'hFFFF_FFF0, 6'd7, 5'd3), 1'b1, 1'b0);
    repeat (3) step(nop(), 1'b1, 1'b0);

    // signed / unsigned compare and arithmetic shift, back to back
    step(mk(4'd2, 6'd1, 32'd1, 6'd1, 5'd1), 1'b1, 1'b0);
    step(mk(4'd3, 6'd1, 32'd1, 6'd2, 5'd2), 1'b1, 1'b0);
    step(mk(4'd9, 6'd2, 32'd4, 6'd3, 5'd3), 1'b1, 1'b0);
    repeat (3) step(nop(), 1'b1, 1'b0);

    // backpressure: 4 ops offered with out_ready low, then released
    for (int i = 0; i < 4; i++) bp[i] = mk(4'(i), 6'(10 + i), 32'(100 * i + 7), 6'(20 + i), 5'(i));
    idx = 0;
    nacc = 0;
    for (int s = 0; s < 5; s++) begin
      step(idx < 4 ? bp[idx] : nop(), 1'b0, 1'b0);
      if (obs_acc0) begin
        idx++;
        nacc++;
      end
    end
    check("bp accepts while stalled", nacc, 2);
    for (int s = 0; s < 8; s++) begin
      step(idx < 4 ? bp[idx] : nop(), 1'b1, 1'b0);
      if (obs_acc0) idx++;
    end
    check("bp all issued", idx, 4);

    // flush with two ops in flight and a third offered
    step(mk(4'd4, 6'd7, 32'h55, 6'd1, 5'd1), 1'b0, 1'b0);
    step(mk(4'd6, 6'd8, 32'h66, 6'd2, 5'd2), 1'b0, 1'b0);
    step(mk(4'd7, 6'd9, 32'h77, 6'd3, 5'd3), 1'b0, 1'b1);
    repeat (2) step(nop(), 1'b1, 1'b0);
    step(mk(4'd1, 6'd5, 32'h3, 6'd4, 5'd4), 1'b1, 1'b0);
    repeat (3) step(nop(), 1'b1, 1'b0);

    // randomized traffic with random backpressure and occasional flush
    for (int s = 0; s < 3000; s++)
      step(rand_op(), $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    repeat (4) step(nop(), 1'b1, 1'b0);

    // reset in the middle of traffic discards in-flight entries
    step(mk(4'd0, 6'd5, 32'd1, 6'd5, 5'd5), 1'b0, 1'b0);
    step(mk(4'd0, 6'd5, 32'd2, 6'd6, 5'd6), 1'b0, 1'b0);
    do_reset();
    repeat (4) step(nop(), 1'b1, 1'b0);

    // 64-bit, 4-stage instance
    run_w("w64 sll", 4'd5, 64'd1, 64'd40, 64'h0000_0100_0000_0000, 1'b0);
    run_w("w64 sra", 4'd9, 64'h8000_0000_0000_0000, 64'd36, 64'hFFFF_FFFF_F800_0000, 1'b0);
    run_w("w64 rsv12", 4'd12, 64'd123, 64'd456, 64'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, pipelined integer ALU functional unit for the OoO backend. It sits between the ALU reservation station and the CDB/writeback arbiter. Relative to the single-stage unit it adds:
- configurable data width and pipeline depth;
- a valid/ready handshake on both sides, with full backpressure;
- a global flush.
Per-entry tags (dest physical reg, ROB index) travel with each result.

Parameters:
XLEN, 32, operand/result width (32 or 64)
P_WIDTH, 6, physical register address width
ROB_WIDTH, 5, ROB index width
STAGES, 2, pipeline depth from accept to out_valid, legal 1..4

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-low (reset when rst==0 at posedge)
flush  in  1  kill all in-flight entries (mispredict/exception)
in_valid  in  1  RS issues an op
in_ready  out  1  unit can accept this cycle
in_aluop  in  4  0 add,1 sub,2 slt,3 sltu,4 xor,5 sll,6 or,7 and,8 srl,9 sra; 10-15 reserved
in_m1_sel  in  1  0: a=rs1 data, 1: a=in_pc (zero-extended to XLEN)
in_m2_sel  in  1  0: b=rs2 data, 1: b=in_imm
in_rs1_use  in  1  rs1 read needed
in_rs2_use  in  1  rs2 read needed
in_rs1_paddr  in  P_WIDTH  source 1 phys reg
in_rs2_paddr  in  P_WIDTH  source 2 phys reg
in_pc  in  32  instruction PC
in_imm  in  XLEN  sign-extended immediate
in_pd  in  P_WIDTH  dest phys reg
in_rd_we  in  1  writes a register
in_rob_idx  in  ROB_WIDTH  ROB slot
rs1_paddr  out  P_WIDTH  PRF read addr = in_rs1_use ? in_rs1_paddr : 0 (combinational)
rs2_paddr  out  P_WIDTH  PRF read addr = in_rs2_use ? in_rs2_paddr : 0 (combinational)
p1_data  in  XLEN  PRF data, same-cycle (combinational read)
p2_data  in  XLEN  PRF data, same-cycle
out_valid  out  1  result available
out_ready  in  1  writeback accepts
out_data  out  XLEN  result
out_pd  out  P_WIDTH  dest phys reg
out_rd_we  out  1  dest write enable
out_rob_idx  out  ROB_WIDTH  ROB slot
out_illegal  out  1  reserved aluop was issued

Behaviour:
- Accept: occurs when in_valid && in_ready && !flush at posedge. Operands are sampled from p1_data/p2_data in that cycle. The result is computed combinationally and registered into stage 1 with its tags.
- Stages 2..STAGES: delay registers only. out_* are driven from stage STAGES, and out_valid = that stage's valid bit. Latency is exactly STAGES cycles from accept to out_valid, with no stalls.
- Stage advance: stage k advances if it is empty, or if stage k+1 advances (or the output handshakes, for k=STAGES).
- in_ready: = stage 1 empty || stage 1 advances. It is combinational, and may depend on out_ready but never on in_valid.
- Holding: a held stage keeps its contents unchanged. Throughput is 1 op/cycle when out_ready is held high, and there are no bubbles under continuous issue.
- Arithmetic:
  - add/sub wrap mod 2^XLEN.
  - slt is signed; sltu is unsigned; both produce 1 or 0 zero-extended.
  - Shift amount is b[4:0] for XLEN=32 and b[5:0] for XLEN=64.
  - sra is arithmetic.
- Reserved ops (10-15): out_data=0 and out_illegal=1, travelling with the entry; the entry still completes normally.
- Flush: all stage valid bits clear at that posedge. Any in_valid that cycle is dropped, and in_ready may be high. out_valid is 0 the following cycle. A flush coincident with an output handshake: the handshake counts (consumer sampled it); the pipeline still empties.
- Reset (rst==0 at posedge): all valid bits are 0. out_valid=0, out_data=0, out_pd=0, out_rd_we=0, out_rob_idx=0, out_illegal=0. in_ready=1 from the first cycle after reset deasserts. Reset mid-operation discards in-flight entries; no output is produced for them.
- Simultaneous conditions:
  - Full pipeline with out_ready=0: in_ready=0 and nothing moves.
  - out_ready rising while in_valid is high: accept and drain occur in the same cycle.
- Data/tag registers need no reset beyond the out_* registers listed above; valid bits must reset.

Test Plan:
- Reset, STAGES=2: hold rst=0 for 2 cycles, release -> out_valid=0, out_data=0, in_ready=1.
- Add with imm: rs1 data=0x0000_0010, imm=0xFFFF_FFF0, op add, m2_sel=1, pd=7, rob=3 accepted at cycle N -> at N+2, out_valid=1, out_data=0, out_pd=7, out_rob_idx=3.
- Signed ops: op slt with a=0xFFFF_FFFF, b=1 -> out_data=1. Op sltu with the same operands -> 0. Op sra with a=0x8000_0000, b=4 -> 0xF800_0000.
- Backpressure, STAGES=2: issue 4 back-to-back ops with out_ready=0 -> in_ready falls after 2 accepts. Raise out_ready -> 4 results in issue order on 4 consecutive cycles, none lost or duplicated.
- Flush: 2 ops in flight, assert flush with in_valid=1 -> no out_valid for any of the 3. The next op accepted afterwards appears after exactly STAGES cycles.
- Parameter sweep: STAGES=1 and 4, XLEN=64 with sll of a=1 by b=40 -> latency equals STAGES and out_data=0x0000_0100_0000_0000. Reserved aluop=12 -> out_illegal=1, out_data=0.
